// File: rtl/vector_result_serializer.sv
// vector_result_serializer: captures a result vector on load and streams it as
// a length byte followed by each element little-endian over a byte valid/ready link.
`default_nettype none

module vector_result_serializer #(
  parameter int BITS = 8,
  parameter int N    = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [BITS-1:0] S [N-1:0],
  input  logic [7:0]      S_len,
  input  logic            load,
  output logic            busy,
  output logic            done,
  output logic [7:0]      tx_data,
  output logic            tx_valid,
  input  logic            tx_ready
);

  localparam int BYTES = BITS / 8;
  localparam int EW    = $clog2(N + 1);
  localparam int BW    = $clog2(BYTES) + 1;
  localparam int IW    = (N > 1) ? $clog2(N) : 1;

  localparam logic [7:0]    N_LEN     = 8'(N);
  localparam logic [BW-1:0] LAST_BYTE = BW'(BYTES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [BITS-1:0] cap_q [N-1:0];
  logic [BITS-1:0] cap_d [N-1:0];
  logic [7:0]      len_q, len_d;
  logic [EW-1:0]   elem_q, elem_d;
  logic [BW-1:0]   byte_q, byte_d;
  logic            done_q, done_d;

  logic [BITS-1:0] elem_word;
  logic            last_byte;
  logic            last_elem;

  assign elem_word = cap_q[elem_q[IW-1:0]];
  assign last_byte = (byte_q == LAST_BYTE);
  assign last_elem = (8'(elem_q) == (len_q - 8'd1));

  // Outputs come only from registered state, so tx_valid never sees tx_ready.
  assign busy     = (state_q != IDLE);
  assign tx_valid = (state_q != IDLE);
  assign done     = done_q;

  always_comb begin
    tx_data = 8'd0;
    case (state_q)
      HDR:     tx_data = len_q;
      DATA:    tx_data = 8'(elem_word >> {byte_q, 3'b000});
      default: tx_data = 8'd0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cap_d   = cap_q;
    len_d   = len_q;
    elem_d  = elem_q;
    byte_d  = byte_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (load) begin
          cap_d   = S;
          len_d   = (S_len > N_LEN) ? N_LEN : S_len;
          elem_d  = '0;
          byte_d  = '0;
          state_d = HDR;
        end
      end
      HDR: begin
        if (tx_ready) begin
          elem_d = '0;
          byte_d = '0;
          if (len_q == 8'd0) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (tx_ready) begin
          if (last_byte) begin
            byte_d = '0;
            if (last_elem) begin
              elem_d  = '0;
              state_d = IDLE;
              done_d  = 1'b1;
            end else begin
              elem_d = elem_q + EW'(1);
            end
          end else begin
            byte_d = byte_q + BW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      len_q   <= '0;
      elem_q  <= '0;
      byte_q  <= '0;
      done_q  <= 1'b0;
      for (int i = 0; i < N; i++) begin
        cap_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      elem_q  <= elem_d;
      byte_q  <= byte_d;
      done_q  <= done_d;
      for (int i = 0; i < N; i++) begin
        cap_q[i] <= cap_d[i];
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_vector_result_serializer.sv
// Directed bench for vector_result_serializer: 8-bit and 16-bit element instances.
`default_nettype none

module tb_vector_result_serializer;

  logic clk = 1'b0;
  logic rst;
  logic tx_ready;
  logic sel;

  logic [7:0]  s8 [3:0];
  logic [7:0]  len8;
  logic        load8, busy8, done8, valid8;
  logic [7:0]  data8;

  logic [15:0] s16 [3:0];
  logic [7:0]  len16;
  logic        load16, busy16, done16, valid16;
  logic [7:0]  data16;

  logic       m_busy, m_done, m_valid;
  logic [7:0] m_data;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  vector_result_serializer #(.BITS(8), .N(4)) dut8 (
    .clk(clk), .rst(rst), .S(s8), .S_len(len8), .load(load8),
    .busy(busy8), .done(done8), .tx_data(data8), .tx_valid(valid8),
    .tx_ready(tx_ready)
  );

  vector_result_serializer #(.BITS(16), .N(4)) dut16 (
    .clk(clk), .rst(rst), .S(s16), .S_len(len16), .load(load16),
    .busy(busy16), .done(done16), .tx_data(data16), .tx_valid(valid16),
    .tx_ready(tx_ready)
  );

  assign m_busy  = sel ? busy16  : busy8;
  assign m_done  = sel ? done16  : done8;
  assign m_valid = sel ? valid16 : valid8;
  assign m_data  = sel ? data16  : data8;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set8(input logic [7:0] a0, a1, a2, a3, input logic [7:0] n);
    s8[0] = a0; s8[1] = a1; s8[2] = a2; s8[3] = a3;
    len8 = n;
  endtask

  task automatic pulse_load8();
    load8 = 1'b1;
    step();
    load8 = 1'b0;
  endtask

  task automatic expect_byte(input string tag, input logic [7:0] b);
    tx_ready = 1'b1;
    check({tag, "_valid"}, 32'(m_valid), 32'd1);
    check({tag, "_data"},  32'(m_data),  32'(b));
    check({tag, "_busy"},  32'(m_busy),  32'd1);
    check({tag, "_done"},  32'(m_done),  32'd0);
    step();
  endtask

  task automatic expect_done(input string tag);
    check({tag, "_done"},    32'(m_done),  32'd1);
    check({tag, "_busy"},    32'(m_busy),  32'd0);
    check({tag, "_idlevld"}, 32'(m_valid), 32'd0);
    step();
    check({tag, "_donegone"}, 32'(m_done), 32'd0);
  endtask

  // Walks one frame from its header cycle; alt=1 drives tx_ready 1,0,1,0...
  task automatic run_frame(input string tag, input logic [7:0] exp[$], input bit alt);
    int idx = 0;
    int cyc = 0;
    while (idx < exp.size() && cyc < 64) begin
      tx_ready = alt ? (cyc % 2 == 0) : 1'b1;
      check({tag, "_valid"}, 32'(m_valid), 32'd1);
      check({tag, "_data"},  32'(m_data),  32'(exp[idx]));
      check({tag, "_busy"},  32'(m_busy),  32'd1);
      check({tag, "_done"},  32'(m_done),  32'd0);
      if (tx_ready) idx++;
      step();
      cyc++;
    end
    check({tag, "_bytes"}, 32'(idx), 32'(exp.size()));
    if (!alt) check({tag, "_cycles"}, 32'(cyc), 32'(exp.size()));
    tx_ready = 1'b1;
    expect_done(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; tx_ready = 1'b0; sel = 1'b0;
    load8 = 1'b0; load16 = 1'b0;
    set8(8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
    for (int i = 0; i < 4; i++) s16[i] = 16'd0;
    len16 = 8'd0;
    step();
    step();
    check("rst_valid", 32'(valid8), 32'd0);
    check("rst_busy",  32'(busy8),  32'd0);
    check("rst_done",  32'(done8),  32'd0);
    check("rst_data",  32'(data8),  32'd0);
    rst = 1'b0;
    step();

    // 1: full-rate frame
    set8(8'd0, 8'd5, 8'd10, 8'd20, 8'd4);
    pulse_load8();
    run_frame("t1", '{8'h04, 8'h00, 8'h05, 8'h0A, 8'h14}, 1'b0);

    // 2: same frame with alternating ready
    pulse_load8();
    run_frame("t2", '{8'h04, 8'h00, 8'h05, 8'h0A, 8'h14}, 1'b1);

    // 3: empty vector
    set8(8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'd0);
    pulse_load8();
    run_frame("t3", '{8'h00}, 1'b0);

    // 4: oversize length is clamped to N
    set8(8'd1, 8'd2, 8'd3, 8'd4, 8'd9);
    pulse_load8();
    run_frame("t4", '{8'h04, 8'h01, 8'h02, 8'h03, 8'h04}, 1'b0);

    // 5a: loads during a frame are ignored
    set8(8'h11, 8'h22, 8'h33, 8'h44, 8'd4);
    pulse_load8();
    set8(8'h99, 8'h98, 8'h97, 8'h96, 8'd2);
    load8 = 1'b1;
    expect_byte("t5a_h", 8'h04);
    expect_byte("t5a_0", 8'h11);
    load8 = 1'b0;
    expect_byte("t5a_1", 8'h22);
    expect_byte("t5a_2", 8'h33);
    expect_byte("t5a_3", 8'h44);
    expect_done("t5a");

    // 5b: reset after the second byte drops the frame without done
    set8(8'h11, 8'h22, 8'h33, 8'h44, 8'd4);
    pulse_load8();
    expect_byte("t5b_h", 8'h04);
    expect_byte("t5b_0", 8'h11);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t5b_rst_valid", 32'(valid8), 32'd0);
    check("t5b_rst_busy",  32'(busy8),  32'd0);
    check("t5b_rst_done",  32'(done8),  32'd0);
    check("t5b_rst_data",  32'(data8),  32'd0);
    step();
    check("t5b_post_done",  32'(done8),  32'd0);
    check("t5b_post_valid", 32'(valid8), 32'd0);

    // 5c: fresh frame, then a load in the done cycle starts the next one
    set8(8'h7E, 8'h00, 8'h00, 8'h00, 8'd1);
    pulse_load8();
    expect_byte("t5c_h", 8'h01);
    expect_byte("t5c_0", 8'h7E);
    check("t5c_done", 32'(done8), 32'd1);
    check("t5c_busy", 32'(busy8), 32'd0);
    set8(8'h5A, 8'hC3, 8'h00, 8'h00, 8'd2);
    pulse_load8();
    run_frame("t5d", '{8'h02, 8'h5A, 8'hC3}, 1'b0);

    // 6: 16-bit elements, LS byte first
    sel = 1'b1;
    s16[0] = 16'h1234; s16[1] = 16'hFF00; len16 = 8'd2;
    load16 = 1'b1;
    step();
    load16 = 1'b0;
    run_frame("t6", '{8'h02, 8'h34, 8'h12, 8'h00, 8'hFF}, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
